// File: rtl/bf16_mul_pipe.sv
// -----------------------------------------------------------------------------
// bf16_mul_pipe
//
// Pipelined, multi-lane bf16 x bf16 -> fp32 multiplier. Each accepted beat
// carries NUM_LANES independent operand pairs and a rounding mode. The product
// for every lane emerges three cycles after the accepting cycle.
//
//   S1 : unpack, 8x8 mantissa multiply, biased exponent sum
//   S2 : full normalisation (leading-one placed at man[15])
//   S3 : overflow / normal / subnormal packing with rounding, flag generation
//
// All three stages advance together only when the output register is free or
// being consumed; bubbles travel through the pipe and are not compressed.
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     input beat accepted when in_valid && in_ready
//   in_a, in_b   bf16 operands, lane i at [16i+15:16i]
//   in_lane_en   per-lane enable; a disabled lane yields +0 and no flags
//   in_rnd       0 = round-to-nearest-even, 1 = round-toward-zero
//   out_valid    output beat valid
//   out_ready    output beat consumed when out_valid && out_ready
//   out_p        fp32 products, lane i at [32i+31:32i]
//   flag_ovf     sticky per-lane overflow-to-Inf flag
//   flag_unf     sticky per-lane inexact-subnormal / flushed-to-zero flag
//   flag_clr     synchronous clear of both flag vectors (a same-cycle set wins)
//   inflight     number of valid beats held in stages 1..3
//
// Build option
//   BF16_MUL_SPECIAL_EN : when defined, IEEE NaN / Inf operands are honoured
//   (NaN and Inf*0 give canonical qNaN 0x7FC00000, Inf*finite gives signed
//   Inf without an overflow flag). When undefined, exponent-255 operands are
//   ordinary normals and simply overflow.
// -----------------------------------------------------------------------------
module bf16_mul_pipe #(
   parameter int NUM_LANES = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [16*NUM_LANES-1:0]   in_a,
   input  logic [16*NUM_LANES-1:0]   in_b,
   input  logic [NUM_LANES-1:0]      in_lane_en,
   input  logic                      in_rnd,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [32*NUM_LANES-1:0]   out_p,
   output logic [NUM_LANES-1:0]      flag_ovf,
   output logic [NUM_LANES-1:0]      flag_unf,
   input  logic                      flag_clr,
   output logic [1:0]                inflight
);

   // ---------------------------------------------------------------------------
   // Per-lane stage payloads
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic        en;
      logic        sign;
      logic        special;     // result fully decided in S1 (NaN / Inf)
      logic [31:0] spec_val;
      logic [15:0] prod;        // 1.xx * 1.xx, binary point after bit 14
      logic [9:0]  exp;         // two's complement biased exponent
   } s1_lane_t;

   typedef struct packed {
      logic        en;
      logic        sign;
      logic        special;
      logic [31:0] spec_val;
      logic        zero;
      logic [15:0] man;         // leading one at bit 15
      logic [9:0]  exp;         // two's complement biased exponent
   } s2_lane_t;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
   } s3_lane_t;

   // ---------------------------------------------------------------------------
   // Leading-zero count over a 15-bit field; returns 14 when only bit 0 (or
   // nothing) is set. The all-zero product is handled separately.
   // ---------------------------------------------------------------------------
   function automatic logic [3:0] lzc15(input logic [14:0] v);
      logic [3:0] n;
      n = 4'd14;
      for (int i = 0; i <= 14; i++) begin
         if (v[i]) n = 4'(14 - i);
      end
      return n;
   endfunction

   // ---------------------------------------------------------------------------
   // S1: unpack and multiply
   // ---------------------------------------------------------------------------
   function automatic s1_lane_t stage1(input logic [15:0] a,
                                       input logic [15:0] b,
                                       input logic        en);
      s1_lane_t   r;
      logic [7:0] ea, eb, ma, mb;
`ifdef BF16_MUL_SPECIAL_EN
      logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
`endif
      // Subnormal operands use effective exponent 1 and no implicit bit.
      ea         = (a[14:7] == 8'd0) ? 8'd1 : a[14:7];
      eb         = (b[14:7] == 8'd0) ? 8'd1 : b[14:7];
      ma         = {(a[14:7] != 8'd0), a[6:0]};
      mb         = {(b[14:7] != 8'd0), b[6:0]};
      r.en       = en;
      r.sign     = a[15] ^ b[15];
      r.prod     = {8'd0, ma} * {8'd0, mb};
      r.exp      = {2'b00, ea} + {2'b00, eb} - 10'd127;
      r.special  = 1'b0;
      r.spec_val = 32'd0;
`ifdef BF16_MUL_SPECIAL_EN
      a_nan  = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
      b_nan  = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
      a_inf  = (a[14:7] == 8'hFF) && (a[6:0] == 7'd0);
      b_inf  = (b[14:7] == 8'hFF) && (b[6:0] == 7'd0);
      a_zero = (a[14:0] == 15'd0);
      b_zero = (b[14:0] == 15'd0);
      if (a_nan || b_nan) begin
         r.special  = 1'b1;
         r.spec_val = 32'h7FC0_0000;
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         r.special  = 1'b1;
         r.spec_val = 32'h7FC0_0000;
      end else if (a_inf || b_inf) begin
         r.special  = 1'b1;
         r.spec_val = {r.sign, 8'hFF, 23'd0};
      end
`endif
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // S2: normalise so the leading one sits at man[15]
   // ---------------------------------------------------------------------------
   function automatic s2_lane_t stage2(input s1_lane_t x);
      s2_lane_t   r;
      logic [3:0] lz;
      r.en       = x.en;
      r.sign     = x.sign;
      r.special  = x.special;
      r.spec_val = x.spec_val;
      r.zero     = (x.prod == 16'd0);
      lz         = lzc15(x.prod[14:0]);
      if (x.prod[15]) begin
         // Product in [2,4): value is already man/2^15 with exponent + 1.
         r.man = x.prod;
         r.exp = x.exp + 10'd1;
      end else begin
         r.man = x.prod << (lz + 4'd1);
         r.exp = x.exp - {6'd0, lz};
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // S3: pack to fp32, round subnormals, raise flags
   // ---------------------------------------------------------------------------
   function automatic s3_lane_t stage3(input s2_lane_t x, input logic rnd);
      s3_lane_t          r;
      logic signed [9:0] e;
      logic signed [9:0] sh;
      logic [49:0]       ext;
      logic [23:0]       f;
      logic [23:0]       rf;
      logic              g, st, inc;
      r   = '0;
      e   = $signed(x.exp);
      sh  = 10'sd1 - e;
      ext = '0;
      f   = '0;
      rf  = '0;
      g   = 1'b0;
      st  = 1'b0;
      inc = 1'b0;
      if (!x.en) begin
         r.res = 32'd0;
      end else if (x.special) begin
         r.res = x.spec_val;
      end else if (x.zero) begin
         r.res = {x.sign, 31'd0};
      end else if (e >= 10'sd255) begin
         r.res = {x.sign, 8'hFF, 23'd0};
         r.ovf = 1'b1;
      end else if (e >= 10'sd1) begin
         // 16 significant bits always fit the 23-bit fraction: exact.
         r.res = {x.sign, x.exp[7:0], x.man[14:0], 8'd0};
      end else if (sh > 10'sd25) begin
         r.res = {x.sign, 31'd0};
         r.unf = 1'b1;
      end else begin
         // 24-bit significand shifted right by (1 - e); the 26 extension bits
         // keep every shifted-out bit for guard and sticky.
         ext = {x.man, 8'd0, 26'd0} >> sh[4:0];
         f   = ext[49:26];
         g   = ext[25];
         st  = |ext[24:0];
         inc = !rnd && g && (st || f[0]);
         rf  = f + {23'd0, inc};
         // A carry into bit 23 lands in the exponent field as exp = 1.
         r.res = {x.sign, 7'd0, rf};
         r.unf = g || st;
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Stage registers and combinational stage logic
   // ---------------------------------------------------------------------------
   logic                   adv;
   logic                   s1_valid, s2_valid;
   logic                   s1_rnd, s2_rnd;
   s1_lane_t               s1_d [NUM_LANES];
   s1_lane_t               s1_q [NUM_LANES];
   s2_lane_t               s2_d [NUM_LANES];
   s2_lane_t               s2_q [NUM_LANES];
   s3_lane_t               s3_d [NUM_LANES];
   logic [32*NUM_LANES-1:0] out_d;
   logic [NUM_LANES-1:0]   ovf_vec, unf_vec;
   logic [NUM_LANES-1:0]   ovf_set, unf_set;
   logic                   accept, consume;

   // The whole pipe stalls as one unit; in_ready never looks at in_valid.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;
   assign accept   = in_valid && in_ready;
   assign consume  = out_valid && out_ready;

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         s1_d[i] = stage1(in_a[16*i +: 16], in_b[16*i +: 16], in_lane_en[i]);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_LANES; i++) begin
         s2_d[i] = stage2(s1_q[i]);
      end
   end

   // NOTE: every output of this block gets a default before the loop, so no
   // path leaves a variable unassigned and no latch can be inferred.
   always_comb begin
      out_d   = '0;
      ovf_vec = '0;
      unf_vec = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         s3_d[i]          = stage3(s2_q[i], s2_rnd);
         out_d[32*i +: 32] = s3_d[i].res;
         ovf_vec[i]        = s3_d[i].ovf;
         unf_vec[i]        = s3_d[i].unf;
      end
   end

   // Valid bits move on every advance so bubbles keep their slot.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge value of its source regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         s1_valid  <= in_valid;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
      end
   end

   // Payload registers load only when a valid beat moves into them.
   // NOTE: payload is reset too; out_p must read 0 after reset and the extra
   // reset on the inner stages keeps simulation free of X propagation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_rnd <= 1'b0;
         s2_rnd <= 1'b0;
         out_p  <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            s1_q[i] <= '0;
            s2_q[i] <= '0;
         end
      end else if (adv) begin
         if (in_valid) begin
            s1_q   <= s1_d;
            s1_rnd <= in_rnd;
         end
         if (s1_valid) begin
            s2_q   <= s2_d;
            s2_rnd <= s1_rnd;
         end
         if (s2_valid) begin
            out_p <= out_d;
         end
      end
   end

   // Flags set on the edge that loads a valid beat into the output register.
   assign ovf_set = (adv && s2_valid) ? ovf_vec : '0;
   assign unf_set = (adv && s2_valid) ? unf_vec : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_ovf <= '0;
         flag_unf <= '0;
      end else begin
         flag_ovf <= (flag_ovf & ~{NUM_LANES{flag_clr}}) | ovf_set;
         flag_unf <= (flag_unf & ~{NUM_LANES{flag_clr}}) | unf_set;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight <= 2'd0;
      end else begin
         case ({accept, consume})
            2'b10:   inflight <= inflight + 2'd1;
            2'b01:   inflight <= inflight - 2'd1;
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_bf16_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_bf16_mul_pipe
//
// Directed-vector bench for bf16_mul_pipe (NUM_LANES = 4). Each task drives one
// scenario and compares observed outputs against hand-computed fp32 results.
// Inputs are driven 1 time unit after the rising edge and outputs sampled
// there, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_bf16_mul_pipe;

   localparam int NL = 4;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [16*NL-1:0]  in_a;
   logic [16*NL-1:0]  in_b;
   logic [NL-1:0]     in_lane_en;
   logic              in_rnd;
   logic              out_valid;
   logic              out_ready;
   logic [32*NL-1:0]  out_p;
   logic [NL-1:0]     flag_ovf;
   logic [NL-1:0]     flag_unf;
   logic              flag_clr;
   logic [1:0]        inflight;

   int checks;
   int fails;

   // Stream operands: products by 1.0 keep the operand, by 2.0 add one to the exponent.
   logic [15:0] a_list [5] = '{16'h3F80, 16'h4000, 16'h4040, 16'hC0A0, 16'h4110};

   bf16_mul_pipe #(.NUM_LANES(NL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_lane_en (in_lane_en),
      .in_rnd     (in_rnd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_p      (out_p),
      .flag_ovf   (flag_ovf),
      .flag_unf   (flag_unf),
      .flag_clr   (flag_clr),
      .inflight   (inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] stream_exp(input logic [15:0] a);
      logic [15:0] a2;
      a2 = a + 16'h0080;
      return {a2, 16'h0, a, 16'h0, a2, 16'h0, a, 16'h0};
   endfunction

   // Present one beat with out_ready high, then wait (bounded) for its result.
   // lat counts cycles from the accepting cycle to the cycle out_valid is seen.
   task automatic run_single(input logic [63:0] a, input logic [63:0] b,
                             input logic [3:0] en, input logic rnd,
                             output logic [127:0] p, output int lat,
                             output logic [1:0] inf1);
      in_a       = a;
      in_b       = b;
      in_lane_en = en;
      in_rnd     = rnd;
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat      = 1;
      inf1     = inflight;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      p = out_p;
      @(posedge clk); #1;
   endtask

   task automatic clear_flags();
      flag_clr = 1'b1;
      @(posedge clk); #1;
      flag_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_a       = '0;
      in_b       = '0;
      in_lane_en = '0;
      in_rnd     = 1'b0;
      out_ready  = 1'b1;
      flag_clr   = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (inflight !== 2'd0) begin fails++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
      checks++; if (out_p !== 128'd0) begin fails++; $display("FAIL reset_out_p: got %h want 0", out_p); end
      checks++; if (flag_ovf !== 4'd0) begin fails++; $display("FAIL reset_flag_ovf: got %b want 0000", flag_ovf); end
      checks++; if (flag_unf !== 4'd0) begin fails++; $display("FAIL reset_flag_unf: got %b want 0000", flag_unf); end
   endtask

   task automatic test_basic();
      logic [127:0] p;
      int           lat;
      logic [1:0]   inf1;
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
      // Disabled lanes carry overflowing operands: they must stay +0 and flag nothing.
      run_single({16'h7F00, 16'h7F00, 16'h7F00, 16'h3F80},
                 {16'h7F00, 16'h7F00, 16'h7F00, 16'h4000}, 4'b0001, 1'b0, p, lat, inf1);
      checks++; if (lat != 3) begin fails++; $display("FAIL basic_latency: got %0d want 3", lat); end
      checks++; if (inf1 !== 2'd1) begin fails++; $display("FAIL basic_inflight_1: got %0d want 1", inf1); end
      checks++; if (p !== {32'h0, 32'h0, 32'h0, 32'h4000_0000}) begin fails++; $display("FAIL basic_p: got %h want %h", p, {32'h0, 32'h0, 32'h0, 32'h4000_0000}); end
      checks++; if (inflight !== 2'd0) begin fails++; $display("FAIL basic_inflight_0: got %0d want 0", inflight); end
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_out_valid_drop: got %b want 0", out_valid); end
      checks++; if (flag_ovf !== 4'd0) begin fails++; $display("FAIL basic_flag_ovf: got %b want 0000", flag_ovf); end
      checks++; if (flag_unf !== 4'd0) begin fails++; $display("FAIL basic_flag_unf: got %b want 0000", flag_unf); end
   endtask

   task automatic test_overflow();
      logic [127:0] p;
      int           lat;
      logic [1:0]   inf1;
      // lane3: +0 * -0 = -0, lane2: 1 * -1, lane1: -2^127 * 2^127, lane0: 2^127 * 2^127
      run_single({16'h0000, 16'h3F80, 16'hFF00, 16'h7F00},
                 {16'h8000, 16'hBF80, 16'h7F00, 16'h7F00}, 4'b1111, 1'b0, p, lat, inf1);
      checks++; if (p !== {32'h8000_0000, 32'hBF80_0000, 32'hFF80_0000, 32'h7F80_0000}) begin fails++; $display("FAIL ovf_p: got %h want %h", p, {32'h8000_0000, 32'hBF80_0000, 32'hFF80_0000, 32'h7F80_0000}); end
      checks++; if (flag_ovf !== 4'b0011) begin fails++; $display("FAIL ovf_flag: got %b want 0011", flag_ovf); end
      checks++; if (flag_unf !== 4'b0000) begin fails++; $display("FAIL ovf_unf: got %b want 0000", flag_unf); end

      // A later clean beat must not clear the sticky flags.
      run_single({48'h0, 16'h3F80}, {48'h0, 16'h4000}, 4'b0001, 1'b0, p, lat, inf1);
      checks++; if (p[31:0] !== 32'h4000_0000) begin fails++; $display("FAIL ovf_clean_p: got %h want 40000000", p[31:0]); end
      checks++; if (flag_ovf !== 4'b0011) begin fails++; $display("FAIL ovf_sticky: got %b want 0011", flag_ovf); end

      // flag_clr on the same edge that loads a lane-2 overflow: old flags clear, new one wins.
      in_a       = {16'h0, 16'h7F00, 32'h0};
      in_b       = {16'h0, 16'h7F00, 32'h0};
      in_lane_en = 4'b0100;
      in_rnd     = 1'b0;
      out_ready  = 1'b1;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      flag_clr = 1'b1;
      @(posedge clk); #1;
      flag_clr = 1'b0;
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL clr_collide_valid: got %b want 1", out_valid); end
      checks++; if (out_p !== {32'h0, 32'h7F80_0000, 64'h0}) begin fails++; $display("FAIL clr_collide_p: got %h want %h", out_p, {32'h0, 32'h7F80_0000, 64'h0}); end
      checks++; if (flag_ovf !== 4'b0100) begin fails++; $display("FAIL clr_collide_flag: got %b want 0100", flag_ovf); end
      @(posedge clk); #1;

      clear_flags();
      checks++; if (flag_ovf !== 4'b0000) begin fails++; $display("FAIL clr_alone: got %b want 0000", flag_ovf); end
   endtask

   task automatic test_subnormal();
      logic [127:0] p;
      int           lat;
      logic [1:0]   inf1;
      // lane3: 2^-126 * 1 (min normal), lane2: -2^-133 * 1, lane1: 2^-133 * 2^-133 (flush), lane0: 2^-133 * 1
      run_single({16'h0080, 16'h8001, 16'h0001, 16'h0001},
                 {16'h3F80, 16'h3F80, 16'h0001, 16'h3F80}, 4'b1111, 1'b0, p, lat, inf1);
      checks++; if (p !== {32'h0080_0000, 32'h8001_0000, 32'h0000_0000, 32'h0001_0000}) begin fails++; $display("FAIL subn_p: got %h want %h", p, {32'h0080_0000, 32'h8001_0000, 32'h0000_0000, 32'h0001_0000}); end
      checks++; if (flag_unf !== 4'b0010) begin fails++; $display("FAIL subn_unf: got %b want 0010", flag_unf); end
      checks++; if (flag_ovf !== 4'b0000) begin fails++; $display("FAIL subn_ovf: got %b want 0000", flag_ovf); end
      clear_flags();
   endtask

   task automatic test_rounding();
      logic [127:0] p;
      int           lat;
      logic [1:0]   inf1;
      // lane3: exact 2^-133, lane2: 1.5 ulp (tie, odd), lane1: 0.5 ulp (tie, even), lane0: 0.75 ulp
      run_single({16'h0001, 16'h0DC0, 16'h1A00, 16'h0DC0},
                 {16'h3F80, 16'h2700, 16'h1A00, 16'h2680}, 4'b1111, 1'b0, p, lat, inf1);
      checks++; if (p !== {32'h0001_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001}) begin fails++; $display("FAIL rne_p: got %h want %h", p, {32'h0001_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001}); end
      checks++; if (flag_unf !== 4'b0111) begin fails++; $display("FAIL rne_unf: got %b want 0111", flag_unf); end
      clear_flags();
      run_single({16'h0001, 16'h0DC0, 16'h1A00, 16'h0DC0},
                 {16'h3F80, 16'h2700, 16'h1A00, 16'h2680}, 4'b1111, 1'b1, p, lat, inf1);
      checks++; if (p !== {32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000}) begin fails++; $display("FAIL rtz_p: got %h want %h", p, {32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000}); end
      checks++; if (flag_unf !== 4'b0111) begin fails++; $display("FAIL rtz_unf: got %b want 0111", flag_unf); end
      clear_flags();
   endtask

   task automatic test_specials();
      logic [127:0] p;
      logic [127:0] exp_p;
      logic [3:0]   exp_ovf;
      int           lat;
      logic [1:0]   inf1;
`ifdef BF16_MUL_SPECIAL_EN
      exp_p   = {32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000};
      exp_ovf = 4'b0000;
`else
      exp_p   = {32'h0000_0000, 32'hFF80_0000, 32'h0000_0000, 32'h7F80_0000};
      exp_ovf = 4'b0101;
`endif
      // lane3 disabled NaN*NaN, lane2 -Inf*1, lane1 Inf*0, lane0 NaN*1
      run_single({16'h7FC0, 16'hFF80, 16'h7F80, 16'h7FC0},
                 {16'h7FC0, 16'h3F80, 16'h0000, 16'h3F80}, 4'b0111, 1'b0, p, lat, inf1);
      checks++; if (lat != 3) begin fails++; $display("FAIL spec_latency: got %0d want 3", lat); end
      checks++; if (p !== exp_p) begin fails++; $display("FAIL spec_p: got %h want %h", p, exp_p); end
      checks++; if (flag_ovf !== exp_ovf) begin fails++; $display("FAIL spec_ovf: got %b want %b", flag_ovf, exp_ovf); end
      checks++; if (flag_unf !== 4'b0000) begin fails++; $display("FAIL spec_unf: got %b want 0000", flag_unf); end
      clear_flags();
   endtask

   task automatic test_back_to_back();
      logic [127:0] want;
      for (int c = 0; c < 6; c++) begin
         in_valid   = (c < 3);
         in_a       = {4{a_list[(c < 3) ? c : 2]}};
         in_b       = {16'h4000, 16'h3F80, 16'h4000, 16'h3F80};
         in_lane_en = 4'b1111;
         in_rnd     = 1'b0;
         out_ready  = 1'b1;
         #1;
         if (c >= 3) begin
            want = stream_exp(a_list[c-3]);
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid_%0d: got %b want 1", c, out_valid); end
            checks++; if (out_p !== want) begin fails++; $display("FAIL b2b_p_%0d: got %h want %h", c, out_p, want); end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      int           sent;
      int           rcv;
      logic         acc;
      logic         cons;
      logic         saw_valid;
      logic [127:0] want0;
      sent  = 0;
      rcv   = 0;
      want0 = stream_exp(a_list[0]);
      for (int c = 0; c < 40 && rcv < 5; c++) begin
         out_ready  = (c >= 7);
         in_valid   = (sent < 5);
         in_a       = {4{a_list[(sent < 5) ? sent : 4]}};
         in_b       = {16'h4000, 16'h3F80, 16'h4000, 16'h3F80};
         in_lane_en = 4'b1111;
         in_rnd     = 1'b0;
         #1;
         if (c == 3) begin
            checks++; if (sent != 3) begin fails++; $display("FAIL bp_accepted: got %0d want 3", sent); end
         end
         if (c >= 3 && c <= 6) begin
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_c%0d: got %b want 0", c, in_ready); end
            checks++; if (inflight !== 2'd3) begin fails++; $display("FAIL bp_inflight_c%0d: got %0d want 3", c, inflight); end
            checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid_c%0d: got %b want 1", c, out_valid); end
            checks++; if (out_p !== want0) begin fails++; $display("FAIL bp_hold_p_c%0d: got %h want %h", c, out_p, want0); end
         end
         acc  = in_valid && in_ready;
         cons = out_valid && out_ready;
         if (cons) begin
            checks++; if (out_p !== stream_exp(a_list[rcv])) begin fails++; $display("FAIL bp_order_%0d: got %h want %h", rcv, out_p, stream_exp(a_list[rcv])); end
            rcv++;
         end
         @(posedge clk); #1;
         if (acc) sent++;
      end
      in_valid = 1'b0;
      checks++; if (rcv != 5) begin fails++; $display("FAIL bp_received: got %0d want 5", rcv); end

      // Reset pulse with a full, stalled pipe.
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      in_a       = {48'h0, 16'h7F00};
      in_b       = {48'h0, 16'h7F00};
      in_lane_en = 4'b0001;
      repeat (3) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid: got %b want 1", out_valid); end
      checks++; if (inflight !== 2'd3) begin fails++; $display("FAIL rstmid_pre_inflight: got %0d want 3", inflight); end
      checks++; if (flag_ovf !== 4'b0001) begin fails++; $display("FAIL rstmid_pre_ovf: got %b want 0001", flag_ovf); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
      checks++; if (inflight !== 2'd0) begin fails++; $display("FAIL rstmid_inflight: got %0d want 0", inflight); end
      checks++; if (out_p !== 128'd0) begin fails++; $display("FAIL rstmid_out_p: got %h want 0", out_p); end
      checks++; if (flag_ovf !== 4'd0) begin fails++; $display("FAIL rstmid_ovf: got %b want 0000", flag_ovf); end
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      saw_valid = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (out_valid) saw_valid = 1'b1;
      end
      checks++; if (saw_valid !== 1'b0) begin fails++; $display("FAIL rstmid_discard: got out_valid after reset, want none"); end
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_basic();
      test_overflow();
      test_subnormal();
      test_rounding();
      test_specials();
      test_back_to_back();
      test_backpressure();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
